// File: rtl/sync_deframer.sv
// Purpose : find the sync marker in a 32-bit framed stream and forward only payload bytes on an 8-bit stream, with flywheel lock.
// Latency : a payload byte is presented on m_axis the cycle after it is taken from the word register.
// Backpressure: output full and not ready stalls the unpacker in PAYLOAD only; a new word is accepted only as the last byte of the current word is taken.
//
// Ports:
//   core_clk, rst                       clock, asynchronous active-high reset
//   s_axis_input_*   (32-bit, in)       framed words, byte0 = [31:24]; tlast is ignored
//   m_axis_output_*  (8-bit, out)       payload bytes, tlast on the last byte of each frame
//   sync_locked                         frame lock status
//   sync_lost                           one-cycle pulse when lock is dropped
// Optional build macro: SYNC_HAMMING_EN -- the in-lock marker check tolerates up to
// MAX_BIT_ERR flipped bits; acquisition in HUNT always needs an exact match.

module sync_deframer #(
    parameter logic [31:0] SYNC_MARKER = 32'h1ACFFC1D,
    parameter int          PAYLOAD_LEN = 255,
    parameter int          MAX_MISS    = 2,
    parameter int          MAX_BIT_ERR = 2
) (
    input  logic        core_clk,
    input  logic        rst,
    input  logic [31:0] s_axis_input_tdata,
    input  logic        s_axis_input_tvalid,
    input  logic        s_axis_input_tlast,
    output logic        s_axis_input_tready,
    output logic [7:0]  m_axis_output_tdata,
    output logic        m_axis_output_tvalid,
    output logic        m_axis_output_tlast,
    input  logic        m_axis_output_tready,
    output logic        sync_locked,
    output logic        sync_lost
);

    localparam int PADDING_LEN = (4 - ((4 + PAYLOAD_LEN) % 4)) % 4;
    localparam int MISS_W      = (MAX_MISS > 0) ? $clog2(MAX_MISS + 1) : 1;

    localparam logic [7:0]        LAST_CNT = 8'(PAYLOAD_LEN - 1);
    localparam logic [7:0]        PAD_LAST = 8'(PADDING_LEN - 1);
    localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MAX_MISS);
    localparam logic [MISS_W-1:0] MISS_ONE = MISS_W'(1);

    typedef enum logic [1:0] {
        HUNT     = 2'd0,
        PAYLOAD  = 2'd1,
        SKIP_PAD = 2'd2,
        CHECK    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       wreg_q, wreg_d;
    logic              wvalid_q, wvalid_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [31:0]       sr_q, sr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic [7:0]        m_tdata_q, m_tdata_d;
    logic              m_tvalid_q, m_tvalid_d;
    logic              m_tlast_q, m_tlast_d;
    logic              locked_q, locked_d;
    logic              lost_q, lost_d;
    // Holds tready low while in reset and for the release cycle itself.
    logic              rst_done_q;

    logic [7:0]  cur_byte;
    logic [31:0] sr_next;
    logic        out_ready;
    logic        take;
    logic        last_take;
    logic        load;
    logic        check_ok;

    logic unused_ok;
    assign unused_ok = &{1'b0, s_axis_input_tlast, (MAX_BIT_ERR > 0)};

`ifdef SYNC_HAMMING_EN
    function automatic int popcount32(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction
`endif

    always_comb begin
        cur_byte = wreg_q[31:24];
        case (bidx_q)
            2'd0:    cur_byte = wreg_q[31:24];
            2'd1:    cur_byte = wreg_q[23:16];
            2'd2:    cur_byte = wreg_q[15:8];
            default: cur_byte = wreg_q[7:0];
        endcase
    end

    assign sr_next   = {sr_q[23:0], cur_byte};
    assign out_ready = !m_tvalid_q || m_axis_output_tready;
    // Only payload bytes need output space; marker/pad/check bytes drain freely.
    assign take      = wvalid_q && ((state_q != PAYLOAD) || out_ready);
    assign last_take = take && (bidx_q == 2'd3);
    assign s_axis_input_tready = rst_done_q && (!wvalid_q || last_take);
    assign load      = s_axis_input_tvalid && s_axis_input_tready;

`ifdef SYNC_HAMMING_EN
    assign check_ok = (popcount32(sr_next ^ SYNC_MARKER) <= MAX_BIT_ERR);
`else
    assign check_ok = (sr_next == SYNC_MARKER);
`endif

    // Word register and byte index.
    always_comb begin
        wreg_d   = wreg_q;
        wvalid_d = wvalid_q;
        bidx_d   = bidx_q;
        sr_d     = sr_q;
        if (take) begin
            sr_d   = sr_next;
            bidx_d = bidx_q + 2'd1;
            if (last_take) wvalid_d = 1'b0;
        end
        if (load) begin
            wreg_d   = s_axis_input_tdata;
            wvalid_d = 1'b1;
            bidx_d   = 2'd0;
        end
    end

    // Lock FSM and output register.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        miss_d     = miss_q;
        locked_d   = locked_q;
        lost_d     = 1'b0;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;

        if (m_axis_output_tready) begin
            m_tvalid_d = 1'b0;
            m_tlast_d  = 1'b0;
        end

        if (take) begin
            case (state_q)
                HUNT: begin
                    if (sr_next == SYNC_MARKER) begin
                        state_d  = PAYLOAD;
                        cnt_d    = 8'd0;
                        miss_d   = '0;
                        locked_d = 1'b1;
                    end
                end
                PAYLOAD: begin
                    m_tdata_d  = cur_byte;
                    m_tvalid_d = 1'b1;
                    m_tlast_d  = (cnt_q == LAST_CNT);
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = 8'd0;
                        state_d = (PADDING_LEN > 0) ? SKIP_PAD : CHECK;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                SKIP_PAD: begin
                    if (cnt_q == PAD_LAST) begin
                        cnt_d   = 8'd0;
                        state_d = CHECK;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    if (cnt_q == 8'd3) begin
                        cnt_d = 8'd0;
                        if (check_ok) begin
                            miss_d  = '0;
                            state_d = PAYLOAD;
                        end else if (miss_q < MISS_MAX) begin
                            // Flywheel: assume the frame is still aligned.
                            miss_d  = miss_q + MISS_ONE;
                            state_d = PAYLOAD;
                        end else begin
                            // sr keeps its bytes so a marker straddling this window is still found.
                            state_d  = HUNT;
                            locked_d = 1'b0;
                            lost_d   = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            state_q    <= HUNT;
            wreg_q     <= '0;
            wvalid_q   <= 1'b0;
            bidx_q     <= 2'd0;
            sr_q       <= '0;
            cnt_q      <= 8'd0;
            miss_q     <= '0;
            m_tdata_q  <= 8'd0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            locked_q   <= 1'b0;
            lost_q     <= 1'b0;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wreg_q     <= wreg_d;
            wvalid_q   <= wvalid_d;
            bidx_q     <= bidx_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            miss_q     <= miss_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            locked_q   <= locked_d;
            lost_q     <= lost_d;
            rst_done_q <= 1'b1;
        end
    end

    assign m_axis_output_tdata  = m_tdata_q;
    assign m_axis_output_tvalid = m_tvalid_q;
    assign m_axis_output_tlast  = m_tlast_q;
    assign sync_locked          = locked_q;
    assign sync_lost            = lost_q;

endmodule

// File: tb/tb_sync_deframer.sv
`timescale 1ns/1ps
module tb_sync_deframer;
    localparam logic [31:0] MARKER  = 32'h1ACFFC1D;
    localparam int          PLEN    = 255;
    localparam int          PAD     = (4 - ((4 + PLEN) % 4)) % 4;
    localparam int          MAXMISS = 2;
    localparam int          BUDGET  = 6000;

    logic        core_clk = 1'b0;
    logic        rst;
    logic [31:0] s_dat;
    logic        s_vld, s_last, s_rdy;
    logic [7:0]  m_dat;
    logic        m_vld, m_last, m_rdy;
    logic        locked, lost;

    always #5 core_clk = ~core_clk;

    sync_deframer dut (
        .core_clk            (core_clk),
        .rst                 (rst),
        .s_axis_input_tdata  (s_dat),
        .s_axis_input_tvalid (s_vld),
        .s_axis_input_tlast  (s_last),
        .s_axis_input_tready (s_rdy),
        .m_axis_output_tdata (m_dat),
        .m_axis_output_tvalid(m_vld),
        .m_axis_output_tlast (m_last),
        .m_axis_output_tready(m_rdy),
        .sync_locked         (locked),
        .sync_lost           (lost)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0] bq[$];
    logic [7:0] exp_dat[$];
    logic       exp_last[$];
    int         exp_lost;
    logic       exp_locked;
    logic [7:0] got_dat[$];
    logic       got_last[$];
    int         got_lost;
    int         lock_cyc, vld_cyc;
    logic       drv_done, aborted;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        bq.push_back(w[31:24]);
        bq.push_back(w[23:16]);
        bq.push_back(w[15:8]);
        bq.push_back(w[7:0]);
    endtask

    // mode 0: payload 00,01,..; mode 1: random payload
    task automatic push_frame(input logic [31:0] mk, input int mode);
        push_word(mk);
        for (int k = 0; k < PLEN; k++)
            bq.push_back((mode == 0) ? 8'(k) : 8'($urandom_range(0, 255)));
        for (int k = 0; k < PAD; k++) bq.push_back(8'hAC);
    endtask

    function automatic logic [31:0] win(input int p);
        return {bq[p-3], bq[p-2], bq[p-1], bq[p]};
    endfunction

    function automatic logic marker_ok(input logic [31:0] w);
`ifdef SYNC_HAMMING_EN
        return ($countones(w ^ MARKER) <= 2);
`else
        return (w == MARKER);
`endif
    endfunction

    // Reference: walk the byte stream by position. Search for an exact marker; once
    // found, frames are fixed-length slots (marker, payload, pad) and the marker slot
    // after each frame decides whether lock is kept.
    task automatic model();
        int n, p, miss, start, c;
        bit done;
        n = bq.size();
        p = 3;
        done = 0;
        exp_dat.delete();
        exp_last.delete();
        exp_lost = 0;
        exp_locked = 0;
        while (!done) begin
            while (p < n && win(p) != MARKER) p++;
            if (p >= n) break;
            exp_locked = 1;
            miss = 0;
            start = p + 1;
            forever begin
                for (int k = 0; k < PLEN && start + k < n; k++) begin
                    exp_dat.push_back(bq[start+k]);
                    exp_last.push_back(k == PLEN - 1);
                end
                c = start + PLEN + PAD + 3;
                if (c >= n) begin
                    done = 1;
                    break;
                end
                if (marker_ok(win(c))) miss = 0;
                else begin
                    miss++;
                    if (miss > MAXMISS) begin
                        exp_lost++;
                        exp_locked = 0;
                        p = c + 1;
                        break;
                    end
                end
                start = c + 1;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_vld = 1'b0;
        @(posedge core_clk);
        #1;
        rst = 1'b0;
    endtask

    // rdy_mode: 0 always ready, 1 alternating + one 20-cycle hold, 2 random
    task automatic run_scn(input string tag, input int gap_mode, input int rdy_mode, input int abort_at);
        int n;
        while (bq.size() % 4 != 0) bq.push_back(8'($urandom_range(0, 255)));
        model();
        got_dat.delete();
        got_last.delete();
        got_lost = 0;
        lock_cyc = -1;
        vld_cyc = -1;
        drv_done = 0;
        aborted = 0;
        fork
            begin : drv
                int i, cycles;
                bit pend, acc;
                i = 0;
                cycles = 0;
                pend = 0;
                while (i < bq.size() / 4 && !aborted && cycles < BUDGET) begin
                    if (!pend) begin
                        if (gap_mode != 0 && $urandom_range(0, 3) == 0) s_vld = 1'b0;
                        else begin
                            s_vld  = 1'b1;
                            s_dat  = {bq[4*i], bq[4*i+1], bq[4*i+2], bq[4*i+3]};
                            s_last = 1'($urandom_range(0, 1));
                            pend   = 1;
                        end
                    end
                    @(negedge core_clk);
                    acc = s_vld && s_rdy;
                    @(posedge core_clk);
                    #1;
                    if (acc) begin
                        i++;
                        pend = 0;
                        s_vld = 1'b0;
                    end
                    cycles++;
                end
                s_vld = 1'b0;
                if (!aborted) check({tag, "_words_sent"}, i, bq.size() / 4);
                drv_done = 1;
            end
            begin : mon
                int cyc, drain, hold_left;
                bit held, chk_hold;
                cyc = 0;
                drain = 0;
                hold_left = 0;
                held = 0;
                while (!(drv_done && drain >= 60)) begin
                    chk_hold = 0;
                    case (rdy_mode)
                        0:       m_rdy = 1'b1;
                        1:       m_rdy = cyc[0];
                        default: m_rdy = 1'($urandom_range(0, 1));
                    endcase
                    if (rdy_mode == 1 && !held && got_dat.size() >= 50) begin
                        held = 1;
                        hold_left = 20;
                    end
                    if (hold_left > 0) begin
                        m_rdy = 1'b0;
                        hold_left--;
                        chk_hold = (hold_left == 0);
                    end
                    if (drv_done) m_rdy = 1'b1;
                    @(negedge core_clk);
                    if (m_vld && m_rdy) begin
                        got_dat.push_back(m_dat);
                        got_last.push_back(m_last);
                    end
                    if (lost) got_lost++;
                    if (locked && lock_cyc < 0) lock_cyc = cyc;
                    if (m_vld && vld_cyc < 0) vld_cyc = cyc;
                    if (chk_hold) begin
                        check({tag, "_hold_s_rdy"}, s_rdy, 1'b0);
                        check({tag, "_hold_m_vld"}, m_vld, 1'b1);
                    end
                    if (abort_at > 0 && got_dat.size() == abort_at) begin
                        @(posedge core_clk);
                        #3;
                        rst = 1'b1;
                        #1;
                        check({tag, "_rst_m_vld"}, m_vld, 1'b0);
                        check({tag, "_rst_m_last"}, m_last, 1'b0);
                        check({tag, "_rst_locked"}, locked, 1'b0);
                        aborted = 1;
                        break;
                    end
                    @(posedge core_clk);
                    #1;
                    cyc++;
                    if (drv_done) drain++;
                end
            end
        join
        if (abort_at == 0) begin
            check({tag, "_count"}, got_dat.size(), exp_dat.size());
            check({tag, "_lost"}, got_lost, exp_lost);
            check({tag, "_locked"}, locked, exp_locked);
        end
        n = (got_dat.size() < exp_dat.size()) ? got_dat.size() : exp_dat.size();
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_byte%0d", tag, k), got_dat[k], exp_dat[k]);
            check($sformatf("%s_last%0d", tag, k), got_last[k], exp_last[k]);
            if (got_dat[k] !== exp_dat[k] || got_last[k] !== exp_last[k]) break;
        end
        bq.delete();
    endtask

    initial begin
        logic [31:0] mk;
        int r, nj;
        rst = 1'b1;
        s_dat = '0;
        s_vld = 1'b0;
        s_last = 1'b0;
        m_rdy = 1'b0;
        #12;
        check("rst_m_vld", m_vld, 1'b0);
        check("rst_m_last", m_last, 1'b0);
        check("rst_m_dat", m_dat, 8'h00);
        check("rst_locked", locked, 1'b0);
        check("rst_lost", lost, 1'b0);
        check("rst_s_rdy", s_rdy, 1'b0);
        @(posedge core_clk);
        #1;
        rst = 1'b0;
        @(posedge core_clk);
        #1;
        check("s_rdy_after_rst", s_rdy, 1'b1);

        // Aligned single frame with incrementing payload.
        do_reset();
        push_frame(MARKER, 0);
        run_scn("aligned", 0, 0, 0);
        check("aligned_lock_to_vld", vld_cyc - lock_cyc, 1);
        if (got_dat.size() >= PLEN) begin
            check("aligned_first", got_dat[0], 8'h00);
            check("aligned_last_byte", got_dat[PLEN-1], 8'hFE);
            check("aligned_last_flag", got_last[PLEN-1], 1'b1);
        end

        // Marker split across words.
        do_reset();
        bq.push_back(8'h55);
        bq.push_back(8'h55);
        push_frame(MARKER, 0);
        push_frame(MARKER, 1);
        run_scn("misaligned", 1, 2, 0);

        // Flywheel, lock loss, marker inside payload, marker straddling failed check.
        do_reset();
        push_frame(MARKER, 1);
        bq[14] = 8'h1A; bq[15] = 8'hCF; bq[16] = 8'hFC; bq[17] = 8'h1D;
        push_frame(32'h1ACFFC1E, 1);
        push_frame(32'hDEADBEEF, 1);
        bq.push_back(8'h00);
        bq.push_back(8'h00);
        push_frame(MARKER, 1);
        run_scn("flywheel", 0, 2, 0);
        check("flywheel_lost_seen", got_lost, 1);

        // Backpressure: alternating ready plus a long hold.
        do_reset();
        for (int f = 0; f < 3; f++) push_frame(MARKER, 1);
        run_scn("backpressure", 1, 1, 0);

        // Reset mid-payload, then a clean frame.
        do_reset();
        push_frame(MARKER, 0);
        run_scn("midreset", 0, 2, 100);
        do_reset();
        push_frame(MARKER, 0);
        run_scn("after_reset", 1, 2, 0);

        // Randomised streams with corrupted markers.
        for (int s = 0; s < 3; s++) begin
            do_reset();
            nj = $urandom_range(0, 9);
            for (int k = 0; k < nj; k++) bq.push_back(8'($urandom_range(0, 255)));
            for (int f = 0; f < 5; f++) begin
                mk = MARKER;
                r = $urandom_range(0, 3);
                if (f > 0 && r == 0) mk = mk ^ (32'd1 << $urandom_range(0, 31));
                else if (f > 0 && r == 1) mk = $urandom;
                push_frame(mk, 1);
            end
            run_scn($sformatf("random%0d", s), 1, 2, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
